// File: rtl/mem_lsu.sv
// mem_lsu: memory stage. Queues load/store requests from execute in order,
// runs one data-bus access at a time per queue entry, aligns and extends
// load data onto the LOAD register write port, and pulses MEM_flush on a
// misaligned access, illegal funct3 or bus error.
// Ports:
//   clk, rstn (asynchronous reset, active-high)
//   LOAD_vld/STORE_vld/funct3/MEM_address/STORE_fifo_data/LOAD_fifo_rd:
//     request from execute; lsu_ready = queue not full
//   dbus_*: single-outstanding request/grant/response data bus
//   LOAD_reg_wr/rd/data: registered load writeback
//   MEM_flush/MEM_fault_addr: one-cycle fault pulse and faulting address
module mem_lsu #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        LOAD_vld,
    input  logic        STORE_vld,
    input  logic [2:0]  funct3,
    input  logic [31:0] MEM_address,
    input  logic [31:0] STORE_fifo_data,
    input  logic [4:0]  LOAD_fifo_rd,
    output logic        lsu_ready,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_wstrb,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_err,
    output logic        LOAD_reg_wr,
    output logic [4:0]  LOAD_reg_rd,
    output logic [31:0] LOAD_reg_data,
    output logic        MEM_flush,
    output logic [31:0] MEM_fault_addr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        FAULT = 2'd3
    } state_e;

    typedef struct packed {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  rd;
    } entry_t;

    state_e           state_q, state_d;
    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ld_wr_q, ld_wr_d;
    logic [4:0]       ld_rd_q, ld_rd_d;
    logic [31:0]      ld_data_q, ld_data_d;

    entry_t      new_ent;
    entry_t      head;
    entry_t      cand;
    logic        cand_vld;
    logic        cand_bad;
    logic        push;
    logic        pop;
    logic [31:0] shifted;
    logic [31:0] ld_ext;

    assign lsu_ready      = (count_q != (PTR_W+1)'(DEPTH));
    assign MEM_flush      = (state_q == FAULT);
    assign LOAD_reg_wr    = ld_wr_q;
    assign LOAD_reg_rd    = ld_rd_q;
    assign LOAD_reg_data  = ld_data_q;

    always_comb begin
        new_ent      = '0;
        new_ent.st   = ~LOAD_vld;
        new_ent.f3   = funct3;
        new_ent.addr = MEM_address;
        new_ent.data = STORE_fifo_data;
        new_ent.rd   = LOAD_fifo_rd;

        push = (LOAD_vld | STORE_vld) & lsu_ready & ~MEM_flush;
        head = ent_q[rd_ptr_q];

        // With an empty queue the incoming request is examined directly so
        // the bus request can go out the cycle after it is enqueued.
        cand     = (count_q == '0) ? new_ent : head;
        cand_vld = (count_q != '0) | push;

        cand_bad = 1'b0;
        case (cand.f3)
            3'b000, 3'b100: cand_bad = 1'b0;
            3'b001, 3'b101: cand_bad = cand.addr[0];
            3'b010:         cand_bad = (cand.addr[1:0] != 2'b00);
            default:        cand_bad = 1'b1;
        endcase

        state_d = state_q;
        case (state_q)
            IDLE:    if (cand_vld) state_d = cand_bad ? FAULT : REQ;
            REQ:     if (dbus_gnt) state_d = WAIT;
            WAIT:    if (dbus_rvalid) state_d = dbus_err ? FAULT : IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        pop = (state_q == WAIT) & dbus_rvalid & ~dbus_err;

        ent_d    = ent_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (state_q == FAULT) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                ent_d[wr_ptr_q] = new_ent;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end

        dbus_req   = 1'b0;
        dbus_we    = 1'b0;
        dbus_addr  = '0;
        dbus_wdata = '0;
        dbus_wstrb = '0;
        if (state_q == REQ) begin
            dbus_req  = 1'b1;
            dbus_we   = head.st;
            dbus_addr = {head.addr[31:2], 2'b00};
            if (head.st) begin
                case (head.f3[1:0])
                    2'b00: begin
                        dbus_wstrb = 4'b0001 << head.addr[1:0];
                        dbus_wdata = {4{head.data[7:0]}};
                    end
                    2'b01: begin
                        dbus_wstrb = 4'b0011 << head.addr[1:0];
                        dbus_wdata = {2{head.data[15:0]}};
                    end
                    default: begin
                        dbus_wstrb = 4'b1111;
                        dbus_wdata = head.data;
                    end
                endcase
            end
        end

        MEM_fault_addr = (state_q == FAULT) ? head.addr : '0;

        shifted = dbus_rdata >> {head.addr[1:0], 3'b000};
        case (head.f3)
            3'b000:  ld_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ld_ext = {24'h0, shifted[7:0]};
            3'b101:  ld_ext = {16'h0, shifted[15:0]};
            default: ld_ext = shifted;
        endcase

        ld_wr_d   = pop & ~head.st & (head.rd != 5'd0);
        ld_rd_d   = ld_rd_q;
        ld_data_d = ld_data_q;
        if (pop & ~head.st) begin
            ld_rd_d   = head.rd;
            ld_data_d = ld_ext;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ld_wr_q   <= 1'b0;
            ld_rd_q   <= '0;
            ld_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ld_wr_q   <= ld_wr_d;
            ld_rd_q   <= ld_rd_d;
            ld_data_q <= ld_data_d;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end

endmodule
